// File: rtl/dmem_pkg.sv
// Shared definitions for the Y-86 data-memory stage: icodes, FSM states, access decode.
package dmem_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  function automatic logic is_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
  endfunction

  function automatic logic is_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, asynchronous access and debug read ports.
module dmem_array #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       AW       = 10,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  // Contents are power-up initialised and deliberately never reset.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/data_memory_unit.sv
// Y-86 data-memory stage: handshaked, bounds-checked access with configurable wait states.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       LATENCY  = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  input  logic [DATA_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);
  localparam bit                ZERO_LAT = (LATENCY == 0);

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        icode_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              ready_q, resp_q, dmerr_q;
  logic [DATA_W-1:0] valm_q;

  logic [DATA_W-1:0] req_addr, req_wdata;
  logic              req_err;
  logic [3:0]        acc_icode;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_err, acc_fire, mem_we;
  logic [DATA_W-1:0] rd_word, dbg_word;

  always_comb begin
    req_addr  = (icode == I_RET)  ? valA : valE;
    req_wdata = (icode == I_CALL) ? valP : valA;
    req_err   = (req_addr >= DEPTH_W);
  end

  // With no wait states the access uses the live request on the accept edge.
  always_comb begin
    acc_icode = ZERO_LAT ? icode           : icode_q;
    acc_addr  = ZERO_LAT ? req_addr[AW-1:0] : addr_q;
    acc_wdata = ZERO_LAT ? req_wdata       : wdata_q;
    acc_err   = ZERO_LAT ? req_err         : err_q;
    acc_fire  = ZERO_LAT ? ((state_q == IDLE) && req_valid)
                         : ((state_q == WAIT) && (cnt_q == 4'd1));
    mem_we    = acc_fire && is_write(acc_icode) && !acc_err;
  end

  dmem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .INIT_VAL(INIT_VAL)
  ) u_array (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (acc_addr),
    .wdata_i   (acc_wdata),
    .raddr_i   (acc_addr),
    .rdata_o   (rd_word),
    .dbg_addr_i(dbg_addr[AW-1:0]),
    .dbg_data_o(dbg_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      valm_q  <= '0;
      dmerr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            icode_q <= icode;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            ready_q <= 1'b0;
            if (ZERO_LAT) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= 4'(LATENCY);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase

      resp_q <= acc_fire;
      if (acc_fire) begin
        if (is_read(acc_icode)) valm_q <= acc_err ? '0 : rd_word;
        dmerr_q <= acc_err && (is_read(acc_icode) || is_write(acc_icode));
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_q;
  assign valM       = valm_q;
  assign dmem_error = dmerr_q;
  assign dbg_data   = (dbg_addr < DEPTH_W) ? dbg_word : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench: two instances (LATENCY=0 and LATENCY=2) against an array reference model.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv   [2];
  logic [3:0]  ic   [2];
  logic [63:0] va   [2];
  logic [63:0] ve   [2];
  logic [63:0] vp   [2];
  logic [63:0] da   [2];
  logic        rdy  [2];
  logic        rsp  [2];
  logic [63:0] vm   [2];
  logic        er   [2];
  logic [63:0] dd   [2];

  int          checks   = 0;
  int          failures = 0;
  int          LAT [2]  = '{0, 2};

  logic [63:0] mdl    [2][1024];
  logic [63:0] exp_vm [2];
  logic        exp_er [2];

  always #5 clk = ~clk;

  data_memory_unit #(.DATA_W(64), .DEPTH(1024), .LATENCY(0), .INIT_VAL(64'd2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .icode(ic[0]),
    .valA(va[0]), .valE(ve[0]), .valP(vp[0]), .resp_valid(rsp[0]), .valM(vm[0]),
    .dmem_error(er[0]), .dbg_addr(da[0]), .dbg_data(dd[0])
  );

  data_memory_unit #(.DATA_W(64), .DEPTH(1024), .LATENCY(2), .INIT_VAL(64'd2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .icode(ic[1]),
    .valA(va[1]), .valE(ve[1]), .valP(vp[1]), .resp_valid(rsp[1]), .valM(vm[1]),
    .dmem_error(er[1]), .dbg_addr(da[1]), .dbg_data(dd[1])
  );

  // Reference model: what a completed request does to memory, valM and the error flag.
  task automatic model_apply(input int s, input logic [3:0] c, input logic [63:0] a, e, p);
    logic [63:0] addr, wdata;
    logic        inb;
    addr  = (c == 4'h9) ? a : e;
    wdata = (c == 4'h8) ? p : a;
    inb   = addr < 64'd1024;
    case (c)
      4'h4, 4'h8, 4'hA: begin
        if (inb) mdl[s][addr[9:0]] = wdata;
        exp_er[s] = !inb;
      end
      4'h5, 4'h9, 4'hB: begin
        exp_vm[s] = inb ? mdl[s][addr[9:0]] : 64'd0;
        exp_er[s] = !inb;
      end
      default: exp_er[s] = 1'b0;
    endcase
  endtask

  task automatic issue(input int s, input logic [3:0] c, input logic [63:0] a, e, p,
                       output int lat, output logic [63:0] m, output logic err,
                       output logic busy_bad, output logic pulse_bad);
    @(negedge clk);
    ic[s] = c; va[s] = a; ve[s] = e; vp[s] = p; rv[s] = 1'b1;
    @(posedge clk);
    #1 rv[s] = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    @(negedge clk);
    while (!rsp[s] && lat < 20) begin
      if (rdy[s]) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (rdy[s]) busy_bad = 1'b1;
    m = vm[s];
    err = er[s];
    @(negedge clk);
    pulse_bad = rsp[s] || !rdy[s];
    model_apply(s, c, a, e, p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; ic[s] = '0; va[s] = '0; ve[s] = '0; vp[s] = '0; da[s] = '0;
      exp_vm[s] = '0; exp_er[s] = 1'b0;
      for (int i = 0; i < 1024; i++) mdl[s][i] = 64'd2;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      da[s] = 64'd5;
      #1;
      checks++;
      if ({rdy[s], rsp[s], er[s]} !== 3'b100 || vm[s] !== 64'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: ready/resp/err=%b%b%b valM=%h, required 100 valM=0",
                 s, rdy[s], rsp[s], er[s], vm[s]);
      end
      checks++;
      if (dd[s] !== 64'd2) begin
        failures++;
        $display("FAIL reset_dbg dut%0d: dbg_data=%h, required 2", s, dd[s]);
      end
    end
  endtask

  task automatic test_latency2();
    int lat; logic [63:0] m; logic err, bb, pb;
    issue(1, 4'h4, 64'h1234, 64'd10, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (lat !== 3 || err !== 1'b0 || bb || pb) begin
      failures++;
      $display("FAIL lat2_rmmovq: lat=%0d err=%b busy_bad=%b pulse_bad=%b, required 3 0 0 0",
               lat, err, bb, pb);
    end
    issue(1, 4'h5, 64'd0, 64'd10, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (lat !== 3 || m !== 64'h1234 || err !== 1'b0 || bb || pb) begin
      failures++;
      $display("FAIL lat2_mrmovq: lat=%0d valM=%h err=%b busy_bad=%b pulse_bad=%b, required 3 1234 0 0 0",
               lat, m, err, bb, pb);
    end
  endtask

  task automatic test_call_ret();
    int lat; logic [63:0] m; logic err, bb, pb;
    issue(1, 4'h8, 64'hDEAD, 64'd20, 64'h40, lat, m, err, bb, pb);
    issue(1, 4'h9, 64'd20, 64'd999, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (m !== 64'h40 || err !== 1'b0) begin
      failures++;
      $display("FAIL call_ret: valM=%h err=%b, required 40 0", m, err);
    end
    issue(1, 4'hB, 64'd0, 64'd21, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (m !== 64'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL popq_init: valM=%h err=%b, required 2 0", m, err);
    end
  endtask

  task automatic test_error();
    int lat; logic [63:0] m; logic err, bb, pb;
    issue(1, 4'h4, 64'd7, 64'd1024, 64'd0, lat, m, err, bb, pb);
    da[1] = 64'd0;
    #1;
    checks++;
    if (err !== 1'b1 || dd[1] !== 64'd2) begin
      failures++;
      $display("FAIL err_write: err=%b dbg[0]=%h, required 1 2", err, dd[1]);
    end
    da[1] = 64'd1024;
    #1;
    checks++;
    if (dd[1] !== 64'd0) begin
      failures++;
      $display("FAIL dbg_oob: dbg_data=%h, required 0", dd[1]);
    end
    issue(1, 4'h5, 64'd0, 64'h1_0000_0003, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (err !== 1'b1 || m !== 64'd0) begin
      failures++;
      $display("FAIL err_read_wide: err=%b valM=%h, required 1 0", err, m);
    end
    issue(1, 4'h5, 64'd0, 64'd3, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (err !== 1'b0 || m !== 64'd2) begin
      failures++;
      $display("FAIL err_clear: err=%b valM=%h, required 0 2", err, m);
    end
    issue(1, 4'h0, 64'd0, 64'd1024, 64'd0, lat, m, err, bb, pb);
    checks++;
    if (err !== 1'b0 || m !== 64'd2 || lat !== 3) begin
      failures++;
      $display("FAIL nop_icode: err=%b valM=%h lat=%0d, required 0 2 3", err, m, lat);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    @(negedge clk);
    ic[1] = 4'hA; va[1] = 64'd9; ve[1] = 64'd30; vp[1] = '0; rv[1] = 1'b1;
    @(posedge clk);
    #1 rv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rdy[1] !== 1'b1 || rsp[1] !== 1'b0 || vm[1] !== 64'd0 || er[1] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: ready=%b resp=%b valM=%h err=%b, required 1 0 0 0",
               rdy[1], rsp[1], vm[1], er[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp[1] || !rdy[1]) seen = 1'b1;
    end
    da[1] = 64'd30;
    #1;
    checks++;
    if (seen !== 1'b0 || dd[1] !== 64'd2) begin
      failures++;
      $display("FAIL reset_discard: resp_or_busy_seen=%b mem[30]=%h, required 0 2", seen, dd[1]);
    end
    for (int s = 0; s < 2; s++) begin
      exp_vm[s] = '0;
      exp_er[s] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] pat, exp_pat;
    @(negedge clk);
    ic[0] = 4'h4; ve[0] = 64'd51; va[0] = 64'hAAAA; rv[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_resp: resp=%b ready=%b, required 1 0", rsp[0], rdy[0]);
    end
    ve[0] = 64'd52; va[0] = 64'hBBBB;
    @(negedge clk);
    da[0] = 64'd52;
    #1;
    checks++;
    if (rsp[0] !== 1'b0 || rdy[0] !== 1'b1 || dd[0] !== 64'd2) begin
      failures++;
      $display("FAIL b2b_not_in_resp: resp=%b ready=%b mem[52]=%h, required 0 1 2",
               rsp[0], rdy[0], dd[0]);
    end
    @(negedge clk);
    rv[0] = 1'b0;
    #1;
    checks++;
    if (rsp[0] !== 1'b1 || dd[0] !== 64'hBBBB) begin
      failures++;
      $display("FAIL b2b_second: resp=%b mem[52]=%h, required 1 bbbb", rsp[0], dd[0]);
    end
    model_apply(0, 4'h4, 64'hAAAA, 64'd51, 64'd0);
    model_apply(0, 4'h4, 64'hBBBB, 64'd52, 64'd0);
    @(negedge clk);
    ic[0] = 4'h5; ve[0] = 64'd51; rv[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat[k] = rsp[0];
      exp_pat[k] = (k % 2 == 0);
    end
    rv[0] = 1'b0;
    model_apply(0, 4'h5, 64'd0, 64'd51, 64'd0);
    checks++;
    if (pat !== exp_pat || vm[0] !== exp_vm[0]) begin
      failures++;
      $display("FAIL b2b_held: resp pattern=%b valM=%h, required %b %h", pat, vm[0], exp_pat, exp_vm[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0]  tbl [12] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h4, 4'h5, 4'h9};
    int          s, lat;
    logic [3:0]  c;
    logic [63:0] addr, a, e, p, m, probe;
    logic        err, bb, pb;
    for (int n = 0; n < 60; n++) begin
      s = int'($urandom_range(0, 1));
      c = tbl[$urandom_range(0, 11)];
      case ($urandom_range(0, 7))
        0:       addr = 64'd1024 + 64'($urandom_range(0, 3));
        1:       addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: addr = 64'($urandom_range(0, 40));
      endcase
      a = (c == 4'h9) ? addr : {$urandom, $urandom};
      e = (c == 4'h9) ? 64'($urandom_range(0, 2000)) : addr;
      p = {$urandom, $urandom};
      issue(s, c, a, e, p, lat, m, err, bb, pb);
      checks++;
      if (lat !== LAT[s] + 1 || m !== exp_vm[s] || err !== exp_er[s] || bb || pb) begin
        failures++;
        $display("FAIL rand_req%0d dut%0d icode=%h: lat=%0d valM=%h err=%b busy_bad=%b pulse_bad=%b, required lat=%0d valM=%h err=%b",
                 n, s, c, lat, m, err, bb, pb, LAT[s] + 1, exp_vm[s], exp_er[s]);
      end
      probe = 64'($urandom_range(0, 40));
      da[s] = probe;
      #1;
      checks++;
      if (dd[s] !== mdl[s][probe[9:0]]) begin
        failures++;
        $display("FAIL rand_dbg%0d dut%0d addr=%0d: dbg_data=%h, required %h",
                 n, s, probe, dd[s], mdl[s][probe[9:0]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency2();
    test_call_ret();
    test_error();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Parametrised data-memory stage for the Y-86 SEQ/PIPE datapath; successor to the single-cycle memory stage.
Decodes icode to perform the rmmovq/mrmovq/call/ret/pushq/popq memory access with a valid/ready request handshake and a configurable number of wait states.
Adds bounds checking with an error flag, clocked writes and a registered response.
Sits between execute (valA/valE/valP) and write-back (valM).

Parameters:
DATA_W, 64, word width of data and address operands
DEPTH, 1024, number of words; word-indexed, legal addresses 0..DEPTH-1
LATENCY, 1, wait cycles inserted between request accept and access (0..15)
INIT_VAL, 2, value every word holds at time zero

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present this cycle
req_ready  output  1  block can accept a request
icode  input  4  instruction code of the request
valA  input  DATA_W  write data for rmmovq/pushq; address for ret
valE  input  DATA_W  address for rmmovq/mrmovq/call/pushq/popq
valP  input  DATA_W  write data for call
resp_valid  output  1  one-cycle pulse, request complete
valM  output  DATA_W  read data
dmem_error  output  1  address out of range for the completed request
dbg_addr  input  DATA_W  debug read address
dbg_data  output  DATA_W  combinational memory word at dbg_addr (0 if out of range)

Behaviour:
- Reset (async, active-high): state=IDLE, wait counter=0, req_ready=1, resp_valid=0, valM=0, dmem_error=0. Memory contents are not reset; a pending write is discarded.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, resp_valid=1.
- Accept: in IDLE with req_valid=1, latch icode, addr, wdata and error on the edge.
  - addr = valA for ret (9), valE otherwise.
  - wdata = valP for call (8), valA otherwise.
  - error = (addr >= DEPTH).
- Access edge:
  - LATENCY=0: the access happens on the accept edge; next state RESP.
  - LATENCY>0: counter loads LATENCY and state goes to WAIT. Counter decrements each cycle; the edge where counter==1 performs the access, next state RESP.
- Response: resp_valid high exactly one cycle, LATENCY+1 cycles after the accept edge. RESP always returns to IDLE next cycle. A new request can be accepted no earlier than the cycle after RESP.
- Per-icode access:
  - Writes on the access edge: rmmovq (4) and pushq (A) write valA to mem[valE]; call (8) writes valP to mem[valE].
  - Reads registered into valM: mrmovq (5) and popq (B) read mem[valE]; ret (9) reads mem[valA].
- Other icodes: handshake completes normally, with no access, valM unchanged and dmem_error=0.
- Error path: when addr >= DEPTH, no write occurs, a read sets valM=0, and dmem_error=1 during RESP. Address compare uses the full DATA_W; there is no wrap-around or truncation.
- dmem_error and valM hold their values after RESP until the next completed request.
- req_valid while busy (WAIT or RESP) is ignored, not queued.
- Write-then-read of the same word in consecutive requests returns the new value.
- dbg_data is combinational and reflects a write from the cycle after the write edge.

Decomposition:
- Package dmem_pkg:
  - icode constants: I_RMMOVQ=4, I_MRMOVQ=5, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B
  - FSM state enum (IDLE, WAIT, RESP)
  - helper functions is_write(icode) and is_read(icode)
- Sub-module dmem_array(DATA_W, DEPTH, INIT_VAL): storage with one synchronous write port, one asynchronous access read port and one asynchronous debug read port. The FSM, counter, decode and bounds check stay in data_memory_unit.

Test Plan:
- Reset, then idle: req_ready=1, resp_valid=0, valM=0, dmem_error=0. dbg_addr=5 gives dbg_data=2.
- LATENCY=2: rmmovq valE=10, valA=0x1234, then mrmovq valE=10. Each resp_valid arrives 3 cycles after its accept; valM=0x1234; req_ready=0 while busy.
- call valE=20, valP=0x40, then ret valA=20: valM=0x40. A popq at addr 21 (never written) gives valM=2.
- rmmovq valE=1024, valA=7: dmem_error=1 and no write (dbg_addr=0 still reads 2). A following mrmovq at 3 gives dmem_error=0.
- Assert rst during WAIT of a pushq valE=30, valA=9: the FSM returns to IDLE, mem[30] stays 2, and resp_valid is never raised.
- LATENCY=0: back-to-back requests held on req_valid give resp_valid every 2nd cycle. A second request arriving in RESP is not accepted until IDLE.
